// File: rtl/as1802_bus_seq.sv
// as1802_bus_seq: round-robin memory-cycle sequencer driving an 1802-style multiplexed bus with high-byte caching
module as1802_bus_seq #(
    parameter int NUM_CH      = 2,
    parameter int AB_W        = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int HI_CACHE    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*2*AB_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    output logic [NUM_CH-1:0]        ack_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [2:0]               grant_ch_o,
    output logic                     busy_o,
    input  logic                     hi_inval_i,
    input  logic                     ready_i,
    output logic [AB_W-1:0]          address_o,
    input  logic [DATA_W-1:0]        data_in_i,
    output logic [DATA_W-1:0]        data_out_o,
    output logic                     data_oe_o,
    output logic                     tpa_o,
    output logic                     mrd_o,
    output logic                     mwr_o
);
    localparam int AW = 2 * AB_W;
    localparam logic [3:0] NC = 4'(NUM_CH);

    typedef enum logic [2:0] {S_IDLE, S_HI, S_HI2, S_LO, S_WAIT, S_XFER, S_DONE} state_t;

    state_t              state_q;
    logic [2:0]          ptr_q;
    logic                we_q;
    logic [AB_W-1:0]     lo_q;
    logic [AB_W-1:0]     cache_q;
    logic                valid_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic [3:0]          cand;
    logic [2:0]          sel;
    logic                found;
    logic                hit;
    logic [7:0]          req_pad;
    logic [7:0]          we_pad;
    logic [AW-1:0]       sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    assign req_pad   = 8'(req_i);
    assign we_pad    = 8'(we_i);
    assign sel_addr  = addr_i[int'(sel)*AW +: AW];
    assign sel_wdata = wdata_i[int'(sel)*DATA_W +: DATA_W];
    assign hit       = (HI_CACHE != 0) && valid_q && !hi_inval_i && (sel_addr[AW-1:AB_W] == cache_q);
    assign cnt_d     = cnt_q - 4'(cnt_q != 4'd0);

    // Round-robin search: first requester upward from the channel after the last grant
    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        cand  = 4'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            cand = (cand >= NC) ? cand - NC : cand;
            if (!found && req_pad[cand[2:0]]) begin
                found = 1'b1;
                sel   = cand[2:0];
            end
        end
    end

    // Bus-cycle FSM with registered strobes; the cache valid bit is cleared by hi_inval ahead of any fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= 3'(NUM_CH - 1);
            we_q       <= 1'b0;
            lo_q       <= '0;
            cache_q    <= '0;
            valid_q    <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= 4'd0;
            ack_o      <= '0;
            rdata_o    <= '0;
            grant_ch_o <= 3'd0;
            busy_o     <= 1'b0;
            address_o  <= '0;
            data_out_o <= '0;
            data_oe_o  <= 1'b0;
            tpa_o      <= 1'b0;
            mrd_o      <= 1'b1;
            mwr_o      <= 1'b1;
        end else begin
            valid_q <= valid_q && !hi_inval_i;
            case (state_q)
                S_IDLE: if (found) begin
                    grant_ch_o <= sel;
                    ptr_q      <= sel;
                    we_q       <= we_pad[sel];
                    lo_q       <= sel_addr[AB_W-1:0];
                    wdata_q    <= sel_wdata;
                    busy_o     <= 1'b1;
                    mrd_o      <= we_pad[sel];
                    if (hit) begin
                        address_o <= sel_addr[AB_W-1:0];
                        state_q   <= S_LO;
                    end else begin
                        address_o <= sel_addr[AW-1:AB_W];
                        tpa_o     <= 1'b1;
                        cache_q   <= sel_addr[AW-1:AB_W];
                        valid_q   <= !hi_inval_i;
                        state_q   <= S_HI;
                    end
                end
                S_HI: begin
                    tpa_o   <= 1'b0;
                    state_q <= S_HI2;
                end
                S_HI2: begin
                    address_o <= lo_q;
                    state_q   <= S_LO;
                end
                S_LO: begin
                    cnt_q <= 4'(WAIT_STATES);
                    if (we_q) begin
                        data_out_o <= wdata_q;
                        data_oe_o  <= 1'b1;
                    end
                    if (WAIT_STATES == 0 && ready_i) begin
                        mwr_o   <= !we_q;
                        state_q <= S_XFER;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == 4'd0 && ready_i) begin
                        mwr_o   <= !we_q;
                        state_q <= S_XFER;
                    end
                end
                S_XFER: begin
                    mwr_o     <= 1'b1;
                    mrd_o     <= 1'b1;
                    data_oe_o <= 1'b0;
                    busy_o    <= 1'b0;
                    ack_o     <= NUM_CH'(1) << grant_ch_o;
                    if (!we_q) rdata_o <= data_in_i;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    ack_o   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_as1802_bus_seq.sv
// tb_as1802_bus_seq: table-driven bench over three parameterisations (W=0 cached, W=2 cached, uncached)
module tb_as1802_bus_seq;
    typedef struct {
        int         dut;
        int         ch;
        bit         w;
        logic [15:0] a;
        logic [7:0] wd;
        logic [7:0] din;
        int         inval;
        int         lat;
        bit         tpa;
        int         rf;
        int         rt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n_g = 1'b0;
    logic [1:0]  dsel = 2'd0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [7:0]  data_in = '0;
    logic        hi_inval = 1'b0;
    logic        ready = 1'b1;

    logic [1:0] ack_w[3];
    logic [7:0] rdata_w[3];
    logic [2:0] grant_w[3];
    logic       busy_w[3];
    logic [7:0] address_w[3];
    logic [7:0] dout_w[3];
    logic       oe_w[3];
    logic       tpa_w[3];
    logic       mrd_w[3];
    logic       mwr_w[3];

    int checks = 0;
    int errors = 0;
    logic [7:0] last_rd = 8'h00;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        as1802_bus_seq #(
            .NUM_CH(2), .AB_W(8), .DATA_W(8),
            .WAIT_STATES(g == 1 ? 2 : 0),
            .HI_CACHE(g == 2 ? 0 : 1)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n_g && (dsel == 2'(g))),
            .req_i(req),
            .we_i(we),
            .addr_i(addr),
            .wdata_i(wdata),
            .ack_o(ack_w[g]),
            .rdata_o(rdata_w[g]),
            .grant_ch_o(grant_w[g]),
            .busy_o(busy_w[g]),
            .hi_inval_i(hi_inval),
            .ready_i(ready),
            .address_o(address_w[g]),
            .data_in_i(data_in),
            .data_out_o(dout_w[g]),
            .data_oe_o(oe_w[g]),
            .tpa_o(tpa_w[g]),
            .mrd_o(mrd_w[g]),
            .mwr_o(mwr_w[g])
        );
    end

    // dut: 0 = W0 cached, 1 = W2 cached, 2 = uncached; inval: 1 = pulse before, 2 = during grant cycle
    vec_t tbl[15] = '{
        '{0, 0, 0, 16'h1234, 8'h00, 8'hA5, 0, 5, 1, 0, -1},
        '{0, 0, 0, 16'h1240, 8'h00, 8'h5A, 0, 3, 0, 0, -1},
        '{0, 0, 0, 16'h1240, 8'h00, 8'h11, 1, 5, 1, 0, -1},
        '{0, 1, 1, 16'h12FF, 8'h77, 8'h00, 0, 3, 0, 0, -1},
        '{0, 1, 0, 16'h13FF, 8'h00, 8'h22, 0, 5, 1, 0, -1},
        '{0, 0, 0, 16'h1300, 8'h00, 8'h33, 2, 5, 1, 0, -1},
        '{0, 0, 0, 16'h1300, 8'h00, 8'h44, 0, 5, 1, 0, -1},
        '{0, 0, 1, 16'h1301, 8'hC3, 8'h00, 0, 3, 0, 0, -1},
        '{0, 1, 0, 16'hFF00, 8'h00, 8'h66, 0, 5, 1, 0, -1},
        '{0, 1, 0, 16'h00FF, 8'h00, 8'h67, 0, 5, 1, 0, -1},
        '{2, 0, 0, 16'h1234, 8'h00, 8'h81, 0, 5, 1, 0, -1},
        '{2, 0, 0, 16'h1234, 8'h00, 8'h82, 0, 5, 1, 0, -1},
        '{1, 0, 0, 16'h4000, 8'h00, 8'h90, 0, 7, 1, 0, -1},
        '{1, 0, 0, 16'h4001, 8'h00, 8'h91, 0, 5, 0, 0, -1},
        '{1, 1, 1, 16'h5678, 8'h3C, 8'h00, 0, 8, 1, 3, 5}
    };

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic txn(input vec_t v);
        int lat = 0, ntpa = 0, nmrd = 0, nmwr = 0;
        logic [7:0] tpa_a = 0, pa = 0, xa = 0, dmwr = 0, rd = 0, erd;
        logic oe = 0;
        logic [1:0] av = 0;
        if (v.inval == 1) begin
            @(negedge clk) hi_inval = 1'b1;
            @(negedge clk) hi_inval = 1'b0;
        end
        @(negedge clk);
        req[v.ch] = 1'b1;
        we[v.ch] = v.w;
        addr[v.ch*16 +: 16] = v.a;
        wdata[v.ch*8 +: 8] = v.wd;
        data_in = v.din;
        hi_inval = (v.inval == 2);
        ready = 1'b1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            hi_inval = 1'b0;
            ready = !(c >= v.rf && c <= v.rt);
            if (tpa_w[dsel]) begin ntpa++; tpa_a = address_w[dsel]; end
            if (!mrd_w[dsel]) nmrd++;
            if (!mwr_w[dsel]) begin nmwr++; dmwr = dout_w[dsel]; oe = oe_w[dsel]; end
            if (ack_w[dsel] != 0) begin lat = c; av = ack_w[dsel]; rd = rdata_w[dsel]; xa = pa; end
            pa = address_w[dsel];
        end
        @(negedge clk);
        req[v.ch] = 1'b0;
        ready = 1'b1;
        erd = v.w ? last_rd : v.din;
        last_rd = erd;
        chk("latency", lat, v.lat);
        chk("tpa_count", ntpa, v.tpa ? 1 : 0);
        if (v.tpa) chk("tpa_addr", tpa_a, v.a[15:8]);
        chk("xfer_addr", xa, v.a[7:0]);
        chk("ack_onehot", av, 2'b01 << v.ch);
        chk("rdata", rd, erd);
        chk("mrd_low_cycles", nmrd, v.w ? 0 : v.lat - 1);
        chk("mwr_low_cycles", nmwr, v.w ? 1 : 0);
        if (v.w) begin
            chk("data_out", dmwr, v.wd);
            chk("data_oe", oe, 1);
        end
    endtask

    initial begin
        int n;
        bit seen;
        vec_t v;
        // reset state of the cached W=0 instance
        repeat (2) @(posedge clk);
        #1;
        chk("rst_address", address_w[0], 0);
        chk("rst_data_out", dout_w[0], 0);
        chk("rst_data_oe", oe_w[0], 0);
        chk("rst_tpa", tpa_w[0], 0);
        chk("rst_mrd", mrd_w[0], 1);
        chk("rst_mwr", mwr_w[0], 1);
        chk("rst_ack", ack_w[0], 0);
        chk("rst_rdata", rdata_w[0], 0);
        chk("rst_grant", grant_w[0], 0);
        chk("rst_busy", busy_w[0], 0);
        @(negedge clk) rst_n_g = 1'b1;

        // both channels requesting continuously: grants alternate from ch0
        @(negedge clk);
        req = 2'b11;
        addr = {16'h2000, 16'h1000};
        n = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(posedge clk);
            #1;
            if (ack_w[0] != 0) begin
                chk("arb_grant", grant_w[0], n % 2);
                chk("arb_ack", ack_w[0], 2'b01 << (n % 2));
                n++;
            end
        end
        chk("arb_count", n, 4);
        @(negedge clk);
        req = 2'b00;
        addr = '0;
        rst_n_g = 1'b0;
        @(negedge clk) rst_n_g = 1'b1;
        last_rd = 8'h00;

        foreach (tbl[i]) begin
            if (tbl[i].dut != int'(dsel)) begin
                @(negedge clk) dsel = 2'(tbl[i].dut);
                last_rd = 8'h00;
                @(negedge clk);
            end
            txn(tbl[i]);
        end

        // async reset during a write's XFER on the W=2 instance
        @(negedge clk);
        req[0] = 1'b1;
        we[0] = 1'b1;
        addr[15:0] = 16'h5611;
        wdata[7:0] = 8'hE1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = !mwr_w[1];
        end
        chk("abort_reached_xfer", seen, 1);
        #2 rst_n_g = 1'b0;
        #1;
        chk("abort_mwr", mwr_w[1], 1);
        chk("abort_ack", ack_w[1], 0);
        chk("abort_busy", busy_w[1], 0);
        chk("abort_oe", oe_w[1], 0);
        @(negedge clk);
        req = 2'b00;
        we = 2'b00;
        rst_n_g = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack_w[1] != 0) seen = 1'b1;
        end
        chk("abort_no_ack", seen, 0);
        last_rd = 8'h00;
        v = '{1, 0, 0, 16'h5611, 8'h00, 8'hD4, 0, 7, 1, 0, -1};
        txn(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
